// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, sync/blank flag struct and colour-bar table.
package vga_pkg;

    localparam logic [10:0] H_VISIBLE = 11'd640;
    localparam logic [10:0] H_FP      = 11'd16;
    localparam logic [10:0] H_SYNC    = 11'd96;
    localparam logic [10:0] H_BP      = 11'd48;
    localparam logic [10:0] H_TOTAL   = 11'd800;

    localparam logic [10:0] V_VISIBLE = 11'd480;
    localparam logic [10:0] V_FP      = 11'd10;
    localparam logic [10:0] V_SYNC    = 11'd2;
    localparam logic [10:0] V_BP      = 11'd33;
    localparam logic [10:0] V_TOTAL   = 11'd525;

    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } vga_flags_t;

    // Syncs inactive (high) and nothing visible: the idle state of every stage.
    localparam vga_flags_t FLAGS_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

    // Index 0..7: black, blue, green, cyan, red, magenta, yellow, white (RRRGGGBB).
    localparam logic [7:0][7:0] BAR_RGB = {8'hFF, 8'hFC, 8'hE3, 8'hE0,
                                           8'h1F, 8'h1C, 8'h03, 8'h00};

    // RRRGGGBB to three 4-bit DAC values, replicating MSBs to reach full scale.
    function automatic logic [11:0] expand_rgb(input logic [7:0] c);
        return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Tick-enabled, resettable shift register; DEPTH 0 degenerates to a wire.
module vga_delay_line #(
    parameter int             DEPTH   = 1,
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         tick,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_shift
            logic [DEPTH-1:0][W-1:0] stage;

            always_ff @(posedge clk) begin
                if (!resetN) begin
                    stage <= {DEPTH{RST_VAL}};
                end else if (tick) begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_driver.sv
// 640x480@60 VGA timing generator and pin driver with RGB-latency-matched sync/blank.
// Optional colour-bar source enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_driver
    import vga_pkg::*;
#(
    parameter int PIX_DIV     = 2,
    parameter int RGB_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetN,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        testPattern,
`endif
    input  logic [7:0]  RGB_in,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [3:0]  vgaR,
    output logic [3:0]  vgaG,
    output logic [3:0]  vgaB,
    output logic        vgaHS,
    output logic        vgaVS,
    output logic        vgaBlankN
);

    localparam logic [1:0]  DIV_LAST = 2'(PIX_DIV - 1);
    localparam logic [10:0] H_LAST   = H_TOTAL - 11'd1;
    localparam logic [10:0] V_LAST   = V_TOTAL - 11'd1;
    localparam logic [10:0] HS_START = H_VISIBLE + H_FP;
    localparam logic [10:0] HS_END   = HS_START + H_SYNC - 11'd1;
    localparam logic [10:0] VS_START = V_VISIBLE + V_FP;
    localparam logic [10:0] VS_END   = VS_START + V_SYNC - 11'd1;

    logic [1:0] div;
    logic       tick;
    logic       h_last, v_last;

    // With PIX_DIV = 1 the divider never leaves 0, so tick stays high.
    assign tick   = (div == DIV_LAST);
    assign h_last = (pixelX == H_LAST);
    assign v_last = (pixelY == V_LAST);

    always_ff @(posedge clk) begin
        if (!resetN)   div <= 2'd0;
        else if (tick) div <= 2'd0;
        else           div <= div + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            pixelX       <= '0;
            pixelY       <= '0;
            startOfFrame <= 1'b0;
        end else begin
            // Only a real wrap produces the pulse; reset itself lands on (0,0) silently.
            startOfFrame <= tick && h_last && v_last;
            if (tick) begin
                if (h_last) begin
                    pixelX <= '0;
                    pixelY <= v_last ? 11'd0 : pixelY + 11'd1;
                end else begin
                    pixelX <= pixelX + 11'd1;
                end
            end
        end
    end

    vga_flags_t raw, flags_d;

    always_comb begin
        raw     = FLAGS_IDLE;
        raw.hs  = !(pixelX >= HS_START && pixelX <= HS_END);
        raw.vs  = !(pixelY >= VS_START && pixelY <= VS_END);
        raw.vis = (pixelX < H_VISIBLE) && (pixelY < V_VISIBLE);
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int            PW       = 6;
    localparam logic [PW-1:0] PIPE_RST = {FLAGS_IDLE, 3'b000};
    logic [2:0] bar_d;
`else
    localparam int            PW       = 3;
    localparam logic [PW-1:0] PIPE_RST = FLAGS_IDLE;
`endif

    logic [PW-1:0] pipe_in, pipe_out;

`ifdef VGA_TEST_PATTERN_EN
    // The bar index travels with the flags so bars line up with blanking.
    assign pipe_in          = {raw, pixelX[9:7]};
    assign {flags_d, bar_d} = pipe_out;
`else
    assign pipe_in = raw;
    assign flags_d = pipe_out;
`endif

    vga_delay_line #(
        .DEPTH   (RGB_LATENCY),
        .W       (PW),
        .RST_VAL (PIPE_RST)
    ) u_delay (
        .clk    (clk),
        .resetN (resetN),
        .tick   (tick),
        .din    (pipe_in),
        .dout   (pipe_out)
    );

    logic [7:0] colour;

`ifdef VGA_TEST_PATTERN_EN
    assign colour = testPattern ? BAR_RGB[bar_d] : RGB_in;
`else
    assign colour = RGB_in;
`endif

    always_ff @(posedge clk) begin
        if (!resetN) begin
            vgaHS     <= 1'b1;
            vgaVS     <= 1'b1;
            vgaBlankN <= 1'b0;
            vgaR      <= 4'd0;
            vgaG      <= 4'd0;
            vgaB      <= 4'd0;
        end else if (tick) begin
            vgaHS              <= flags_d.hs;
            vgaVS              <= flags_d.vs;
            vgaBlankN          <= flags_d.vis;
            {vgaR, vgaG, vgaB} <= flags_d.vis ? expand_rgb(colour) : 12'd0;
        end
    end

endmodule
